out_uart_tx: RTL and testbench
==============================

OUT_UART_TX -- requirements
Module: out_uart_tx

Interface
REQ-001 Parameter WIDTH, default 16, width of the captured output word; fixed at 16 for this block (two bytes per word).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 4, number of buffered words; power of two, 2..16.
REQ-004 clk_in  input  1  single system clock, all state on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 data_in  input  16  processor output word, sampled every rising edge.
REQ-007 tx  output  1  serial line, 8N1, idle high, registered.
REQ-008 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-009 fifo_full  output  1  high when FIFO holds FIFO_DEPTH words.
REQ-010 drop_cnt  output  8  count of words lost to overflow, saturating.

Function
REQ-011 Change detect: internal last_val register; on an edge where data_in != last_val, the block SHALL push data_in into the FIFO and load last_val with data_in.
REQ-012 last_val SHALL update on every detected change, including dropped ones, so a held value is counted once.
REQ-013 Push while full with no pop on the same edge: word discarded, drop_cnt += 1, saturating at 255.
REQ-014 Push and pop on the same edge while full: pop frees a slot, push accepted, no drop.
REQ-015 FSM states IDLE, START, DATA, STOP; byte_sel flag (0 = high byte, 1 = low byte).
REQ-016 IDLE with FIFO non-empty at an edge: pop word into word register, byte_sel=0, load shift register with word[15:8], go to START; tx=0 after that edge.
REQ-017 IDLE with FIFO empty: stay; tx=1.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7; after bit 7, go to STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; then if byte_sel=0: byte_sel=1, load word[7:0], go to START (no idle gap); if byte_sel=1: go to IDLE.
REQ-021 Word frame SHALL occupy exactly 20*CLKS_PER_BIT cycles; at least one IDLE cycle (tx=1) SHALL separate consecutive words.
REQ-022 Latency: tx falls on the edge after the push edge when the FSM is IDLE.
REQ-023 Bit-timing counter SHALL count 0..CLKS_PER_BIT-1 and wrap; counter width sized for 65535.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-025 busy SHALL be derived combinationally from state (state != IDLE).

Reset
REQ-026 rst_in high SHALL force immediately, without a clock edge: tx=1, busy=0, state IDLE, FIFO empty, fifo_full=0, drop_cnt=0, last_val=0, byte_sel=0, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame; the partial word is not retransmitted.
REQ-028 After release, a non-zero data_in SHALL be pushed on the first rising edge, since last_val=0.

Verification
REQ-029 CLKS_PER_BIT=4, data_in 0x0000->0x12A5 from IDLE: tx one cycle after the push edge = 0 | 0,1,0,0,1,0,0,0 | 1 | 0 | 1,0,1,0,0,1,0,1 | 1, each symbol 4 cycles, 80 cycles total, busy high throughout, then tx=1 and busy=0.
REQ-030 data_in held at 0x12A5 for 500 cycles after that frame: no further start bit, drop_cnt=0.
REQ-031 From IDLE with the FIFO empty, data_in = 1,2,3,4,5,6 on six consecutive edges: push of 6 dropped, drop_cnt=1, fifo_full=1 after edge 6; serial output carries 1,2,3,4,5 in order, each separated by at least one idle cycle.
REQ-032 Assert rst_in asynchronously during the DATA state of the high byte: tx=1 and busy=0 immediately. With data_in=0x0000 at release: no frame. With data_in=0x00FF at release: full frame 0x00,0xFF.
REQ-033 Hold the FIFO full while 300 distinct values arrive: drop_cnt stops at 255 and never wraps.
REQ-034 Full FIFO, push on the same edge the FSM pops: word accepted, drop_cnt unchanged, fifo_full stays 1.

Source files
------------

// File: rtl/out_uart_tx_if.sv
// rtl/out_uart_tx_if.sv - processor-word input and serial/status outputs of the change-capture UART
interface out_uart_tx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             tx;
    logic             busy;
    logic             fifo_full;
    logic [7:0]       drop_cnt;

    modport master (output data_in, input tx, busy, fifo_full, drop_cnt);
    modport slave  (input data_in, output tx, busy, fifo_full, drop_cnt);
endinterface

// File: rtl/out_uart_tx.sv
// rtl/out_uart_tx.sv - captures changes of a 16-bit word into a FIFO and sends each word as two 8N1 bytes
module out_uart_tx #(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input logic          clk_in,
    input logic          rst_in,
    out_uart_tx_if.slave bus
);
    localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] last_val;
    logic [7:0]       low_q, shift_q, drop_q;
    logic [15:0]      bit_cnt;
    logic [2:0]       bit_idx;
    logic             byte_sel, tx_q;
    logic             change, full, pop, push, drop, bit_end;

    assign change  = bus.data_in != last_val;
    assign full    = count == FULL_CNT;
    assign pop     = (state_q == IDLE) && (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push    = change && (!full || pop);
    assign drop    = change && full && !pop;
    assign bit_end = bit_cnt == BIT_LAST;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_d = STOP;
            STOP:    if (bit_end) state_d = byte_sel ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_val <= '0;
            drop_q   <= '0;
            low_q    <= '0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            // last_val follows every change, dropped or not, so a held value counts once.
            if (change) last_val <= bus.data_in;
            if (push)   wr_ptr   <= wr_ptr + AW'(1);
            if (pop)    rd_ptr   <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

            if (state_q == IDLE || bit_end) bit_cnt <= '0;
            else                            bit_cnt <= bit_cnt + 16'd1;

            case (state_q)
                IDLE: if (pop) begin
                    shift_q  <= mem[rd_ptr][15:8];
                    low_q    <= mem[rd_ptr][7:0];
                    byte_sel <= 1'b0;
                    tx_q     <= 1'b0;
                end
                START: if (bit_end) tx_q <= shift_q[0];
                DATA: if (bit_end) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        tx_q <= 1'b1;
                    end else begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end
                end
                STOP: if (bit_end && !byte_sel) begin
                    byte_sel <= 1'b1;
                    shift_q  <= low_q;
                    tx_q     <= 1'b0;
                end
                default: tx_q <= 1'b1;
            endcase
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.fifo_full = full;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_out_uart_tx.sv
// tb/tb_out_uart_tx.sv - directed and randomized bench with a serial-line decoder and byte scoreboard
module tb_out_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    out_uart_tx_if #(.WIDTH(16)) bus();

    out_uart_tx #(.WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of a 16-bit word frame i cycles after the start bit begins.
    function automatic logic frame_bit(input logic [15:0] w, input int i);
        int s, k;
        logic [7:0] b;
        s = i / CPB;
        k = s % 10;
        b = (s < 10) ? w[15:8] : w[7:0];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic compare_rx();
        check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check("rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_drain(output int words);
        int quiet, n;
        logic prev;
        quiet = 0; n = 0; words = 0; prev = bus.busy;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            if (prev && !bus.busy) words++;
            prev  = bus.busy;
            quiet = bus.busy ? 0 : quiet + 1;
        end
        check("drain_bound", 32'(n < 5000), 32'd1);
    endtask

    initial begin : monitor
        logic [7:0] b;
        logic abort;
        forever begin
            @(negedge clk);
            if (!rst && bus.tx === 1'b0) begin
                abort = 1'b0;
                b = '0;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? CPB / 2 : CPB) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (abort) break;
                    if (k == 0)      check("start_mid", 32'(bus.tx), 32'd0);
                    else if (k == 9) check("stop_bit", 32'(bus.tx), 32'd1);
                    else             b[k-1] = bus.tx;
                end
                if (!abort) begin
                    rx_q.push_back(b);
                    repeat (CPB - CPB / 2 - 1) @(negedge clk);
                end
            end
        end
    end

    initial begin : main
        int words, n, it;
        logic seen, wrapped;
        logic [7:0] prev_drop;
        logic [15:0] v;

        rst = 1'b1;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_full", 32'(bus.fifo_full), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        rst = 1'b0;

        // single word 0x12A5, cycle-exact line check
        bus.data_in = 16'h12A5;
        @(negedge clk);
        check("pre_start_tx", 32'(bus.tx), 32'd1);
        for (int i = 0; i < 20 * CPB; i++) begin
            @(negedge clk);
            check("frame_tx", 32'(bus.tx), 32'(frame_bit(16'h12A5, i)));
            check("frame_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check("post_tx", 32'(bus.tx), 32'd1);
        check("post_busy", 32'(bus.busy), 32'd0);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'hA5);

        seen = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (bus.tx === 1'b0) seen = 1'b1;
        end
        check("hold_no_frame", 32'(seen), 32'd0);
        check("hold_drop", 32'(bus.drop_cnt), 32'd0);
        compare_rx();

        // six changes on consecutive edges: the sixth overflows
        for (int k = 1; k <= 6; k++) begin
            bus.data_in = 16'(k);
            @(negedge clk);
        end
        check("burst_drop", 32'(bus.drop_cnt), 32'd1);
        check("burst_full", 32'(bus.fifo_full), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(k));
        end
        wait_drain(words);
        check("burst_words", 32'(words), 32'd5);
        check("burst_empty_full", 32'(bus.fifo_full), 32'd0);
        compare_rx();

        // random bursts that fit the FIFO, values held for random cycle counts
        for (it = 0; it < 10; it++) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                do v = 16'($urandom_range(1, 65535)); while (v == bus.data_in);
                bus.data_in = v;
                exp_q.push_back(v[15:8]);
                exp_q.push_back(v[7:0]);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            wait_drain(words);
            check("rand_words", 32'(words), 32'(n));
            compare_rx();
        end
        check("rand_drop", 32'(bus.drop_cnt), 32'd1);

        // asynchronous reset inside the high byte's data bits
        bus.data_in = 16'hC3C3;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_tx", 32'(bus.tx), 32'd1);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_full", 32'(bus.fifo_full), 32'd0);
        check("async_drop", 32'(bus.drop_cnt), 32'd0);
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx === 1'b0 || bus.busy === 1'b1) seen = 1'b1;
        end
        check("rel_zero_quiet", 32'(seen), 32'd0);
        compare_rx();

        rst = 1'b1;
        bus.data_in = 16'h00FF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ff_wait", 32'(bus.tx), 32'd1);
        @(negedge clk);
        check("rel_ff_start", 32'(bus.tx), 32'd0);
        check("rel_ff_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        wait_drain(words);
        check("rel_ff_words", 32'(words), 32'd1);
        compare_rx();

        // drop counter saturation under a flood of distinct values
        wrapped = 1'b0;
        prev_drop = bus.drop_cnt;
        for (int i = 0; i < 320; i++) begin
            bus.data_in = 16'h1000 + 16'(i);
            @(negedge clk);
            if (bus.drop_cnt < prev_drop) wrapped = 1'b1;
            prev_drop = bus.drop_cnt;
        end
        check("sat_no_wrap", 32'(wrapped), 32'd0);
        check("sat_value", 32'(bus.drop_cnt), 32'd255);
        check("sat_full", 32'(bus.fifo_full), 32'd1);
        rst = 1'b1;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        rst = 1'b0;

        // push landing on the very edge the FSM pops from a full FIFO
        for (int k = 1; k <= 5; k++) begin
            bus.data_in = 16'hA000 + 16'(k);
            exp_q.push_back(8'hA0);
            exp_q.push_back(8'(k));
            @(negedge clk);
        end
        check("pp_full", 32'(bus.fifo_full), 32'd1);
        check("pp_drop0", 32'(bus.drop_cnt), 32'd0);
        n = 0;
        while (bus.busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("pp_frame_len", 32'(n), 32'(20 * CPB - 3));
        bus.data_in = 16'hA006;
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h06);
        @(negedge clk);
        check("pp_drop", 32'(bus.drop_cnt), 32'd0);
        check("pp_still_full", 32'(bus.fifo_full), 32'd1);
        check("pp_busy", 32'(bus.busy), 32'd1);
        bus.data_in = 16'hA007;
        @(negedge clk);
        check("pp_next_drop", 32'(bus.drop_cnt), 32'd1);
        wait_drain(words);
        check("pp_words", 32'(words), 32'd5);
        compare_rx();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
